clk_mon: RTL and testbench

CLK_MON -- requirements
Module: clk_mon

---
 rtl/clk_mon_pkg.sv | 15 +
 rtl/clk_mon_sync.sv | 45 ++++
 rtl/clk_mon.sv | 213 +++++++++++++++++++++
 tb/tb_clk_mon.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and elaboration-time helpers for the clk_mon clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Nominal period in clk_src cycles, rounded to nearest (inputs are positive).
    function automatic int calc_nom(input real src_mhz, input real nom_mhz);
        return $rtoi(src_mhz / nom_mhz + 0.5);
    endfunction

endpackage

// File: rtl/clk_mon_sync.sv
// Two-flop synchroniser for clk_in plus history flop and registered edge strobes.
module clk_mon_sync (
    input  logic clk_src,
    input  logic rst,
    input  logic clk_in,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

    // Edge decode from the synchronised level and its one-cycle history.
    always_comb begin
        sync1_d = clk_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        rise_d  = sync2_q & ~hist_q;
        fall_d  = ~sync2_q & hist_q;
    end

    // Synchroniser, history and strobe registers.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/clk_mon.sv
// Clock monitor: measures clk_in period in clk_src cycles, tracks lock and timeouts.
// Optional period averaging buffer is enabled by defining CLK_MON_AVG_EN.
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter real CLK_SRC  = 125.0,
    parameter real CLK_NOM  = 3.579545,
    parameter int  PERIOD_W = 8,
    parameter int  TOL      = 2,
    parameter int  LOCK_CNT = 16,
    parameter int  AVG_LOG2 = 3
) (
    input  logic                         clk_src,
    input  logic                         rst,
    input  logic                         clk_in,
    output logic                         rise,
    output logic                         fall,
    output logic [PERIOD_W-1:0]          period,
    output logic                         period_vld,
    output logic [PERIOD_W+AVG_LOG2-1:0] period_avg,
    output logic                         avg_vld,
    output logic                         locked,
    output logic                         lost
);

    localparam int NOM     = calc_nom(CLK_SRC, CLK_NOM);
    localparam int TIMEOUT = 2 * NOM;
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int AVG_W   = PERIOD_W + AVG_LOG2;

    localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
    localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] NOM_LO    = PERIOD_W'(NOM - TOL);
    localparam logic [PERIOD_W-1:0] NOM_HI    = PERIOD_W'(NOM + TOL);
    localparam logic [GOOD_W-1:0]   LOCK_C    = GOOD_W'(LOCK_CNT);

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]     good_cnt_q, good_cnt_d;
    logic [GOOD_W-1:0]     good_inc_s;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic                  period_vld_q, period_vld_d;
    logic                  locked_q, locked_d;
    logic                  lost_q, lost_d;
    logic                  avg_vld_q, avg_vld_d;
    logic                  rise_s, fall_s;
    logic                  period_good_s;
    logic                  capture_s;
    logic                  clear_avg_s;

    clk_mon_sync u_sync (
        .clk_src (clk_src),
        .rst     (rst),
        .clk_in  (clk_in),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    assign period_good_s = (cnt_q >= NOM_LO) && (cnt_q <= NOM_HI);
    assign good_inc_s    = (good_cnt_q == LOCK_C) ? good_cnt_q : good_cnt_q + GOOD_W'(1);

    // Period counter, lock FSM and status strobes; a rise outranks a coincident timeout.
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        lost_d       = 1'b0;
        capture_s    = 1'b0;
        clear_avg_s  = 1'b0;

        if (rise_s) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    state_d = MEASURE;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE, LOCKED: begin
                if (rise_s) begin
                    capture_s    = 1'b1;
                    period_d     = cnt_q;
                    period_vld_d = 1'b1;
                    if (period_good_s) begin
                        good_cnt_d = good_inc_s;
                        if ((state_q == MEASURE) && (good_inc_s == LOCK_C)) begin
                            state_d = LOCKED;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        good_cnt_d = '0;
                        state_d    = MEASURE;
                        lost_d     = (state_q == LOCKED);
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d     = IDLE;
                    good_cnt_d  = '0;
                    clear_avg_s = 1'b1;
                    lost_d      = (state_q == LOCKED);
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // Main state and output registers.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            good_cnt_q   <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            avg_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            good_cnt_q   <= good_cnt_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            avg_vld_q    <= avg_vld_d;
        end
    end

`ifdef CLK_MON_AVG_EN
    localparam int AVG_N = 2 ** AVG_LOG2;

    logic [AVG_N-1:0][PERIOD_W-1:0] hist_buf_q, hist_buf_d;
    logic [AVG_W-1:0]               sum_q, sum_d;
    logic [AVG_LOG2:0]              fill_q, fill_d;

    // Sliding-window sum: newest period in, oldest out; empty slots hold zero.
    always_comb begin
        hist_buf_d = hist_buf_q;
        sum_d      = sum_q;
        fill_d     = fill_q;
        if (clear_avg_s) begin
            hist_buf_d = '0;
            sum_d      = '0;
            fill_d     = '0;
        end else if (capture_s) begin
            hist_buf_d = {hist_buf_q[AVG_N-2:0], cnt_q};
            sum_d      = sum_q + AVG_W'(cnt_q) - AVG_W'(hist_buf_q[AVG_N-1]);
            if (fill_q != (AVG_LOG2+1)'(AVG_N)) begin
                fill_d = fill_q + (AVG_LOG2+1)'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            fill_d = fill_q;
        end
        avg_vld_d = (fill_d == (AVG_LOG2+1)'(AVG_N));
    end

    // Averager storage.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            hist_buf_q <= '0;
            sum_q      <= '0;
            fill_q     <= '0;
        end else begin
            hist_buf_q <= hist_buf_d;
            sum_q      <= sum_d;
            fill_q     <= fill_d;
        end
    end

    assign period_avg = sum_q;
`else
    // Without the window, validity tracks whether any period has been captured.
    always_comb begin
        if (clear_avg_s) begin
            avg_vld_d = 1'b0;
        end else if (capture_s) begin
            avg_vld_d = 1'b1;
        end else begin
            avg_vld_d = avg_vld_q;
        end
    end

    assign period_avg = {period_q, {AVG_LOG2{1'b0}}};
`endif

    assign rise       = rise_s;
    assign fall       = fall_s;
    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign avg_vld    = avg_vld_q;
    assign locked     = locked_q;
    assign lost       = lost_q;

endmodule

// File: tb/tb_clk_mon.sv
// Directed self-checking bench for clk_mon with default parameters (NOM=35, TIMEOUT=70).
module tb_clk_mon;
    import clk_mon_pkg::*;

    logic        clk_src = 1'b0;
    logic        rst     = 1'b1;
    logic        clk_in  = 1'b0;
    logic        rise, fall, period_vld, avg_vld, locked, lost;
    logic [7:0]  period;
    logic [10:0] period_avg;

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_rise = 0, n_fall = 0, n_vld = 0, n_lost = 0;
    int last_rise_cyc = 0, lost_cyc = 0, lock_cyc = 0, last_period = 0;
    bit locked_seen = 1'b0;

    clk_mon dut (
        .clk_src    (clk_src),
        .rst        (rst),
        .clk_in     (clk_in),
        .rise       (rise),
        .fall       (fall),
        .period     (period),
        .period_vld (period_vld),
        .period_avg (period_avg),
        .avg_vld    (avg_vld),
        .locked     (locked),
        .lost       (lost)
    );

    always #5 clk_src = ~clk_src;

    task automatic tick();
        @(negedge clk_src);
        cyc++;
        if (rise) begin n_rise++; last_rise_cyc = cyc; end
        if (fall) n_fall++;
        if (period_vld) begin n_vld++; last_period = int'(period); end
        if (lost) begin n_lost++; lost_cyc = cyc; end
        if (locked && !locked_seen) begin locked_seen = 1'b1; lock_cyc = cyc; end
    endtask

    task automatic clear_counts();
        n_rise = 0; n_fall = 0; n_vld = 0; n_lost = 0; locked_seen = 1'b0;
    endtask

    task automatic run_period(input int hi, input int lo);
        clk_in = 1'b1;
        repeat (hi) tick();
        clk_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_in = 1'b0;
        repeat (3) tick();
        total++; if (rise !== 1'b0)       begin bad++; $display("FAIL rst_rise got %0b want 0", rise); end
        total++; if (fall !== 1'b0)       begin bad++; $display("FAIL rst_fall got %0b want 0", fall); end
        total++; if (period !== 8'd0)     begin bad++; $display("FAIL rst_period got %0d want 0", period); end
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL rst_pvld got %0b want 0", period_vld); end
        total++; if (period_avg !== 11'd0) begin bad++; $display("FAIL rst_avg got %0d want 0", period_avg); end
        total++; if (avg_vld !== 1'b0)    begin bad++; $display("FAIL rst_avg_vld got %0b want 0", avg_vld); end
        total++; if (locked !== 1'b0)     begin bad++; $display("FAIL rst_locked got %0b want 0", locked); end
        total++; if (lost !== 1'b0)       begin bad++; $display("FAIL rst_lost got %0b want 0", lost); end
        rst = 1'b0;
        tick();
        total++; if (rise !== 1'b0) begin bad++; $display("FAIL post_rst_rise got %0b want 0", rise); end
        repeat (4) tick();
    endtask

    task automatic test_lock();
        clear_counts();
        repeat (2) run_period(17, 18);
        total++; if (n_vld !== 1)       begin bad++; $display("FAIL first_vld_count got %0d want 1", n_vld); end
        total++; if (last_period !== 35) begin bad++; $display("FAIL first_period got %0d want 35", last_period); end
        repeat (14) run_period(17, 18);
        total++; if (locked_seen !== 1'b0) begin bad++; $display("FAIL early_lock got %0b want 0", locked_seen); end
        run_period(17, 18);
        total++; if (locked_seen !== 1'b1) begin bad++; $display("FAIL lock_seen got %0b want 1", locked_seen); end
        total++; if (lock_cyc - last_rise_cyc !== 1) begin bad++; $display("FAIL lock_latency got %0d want 1", lock_cyc - last_rise_cyc); end
        total++; if (n_lost !== 0)   begin bad++; $display("FAIL lock_lost got %0d want 0", n_lost); end
        total++; if (n_rise !== 17)  begin bad++; $display("FAIL rise_count got %0d want 17", n_rise); end
        total++; if (n_fall !== 17)  begin bad++; $display("FAIL fall_count got %0d want 17", n_fall); end
        total++; if (n_vld !== 16)   begin bad++; $display("FAIL vld_count got %0d want 16", n_vld); end
        total++; if (period_avg !== 11'd280) begin bad++; $display("FAIL lock_avg got %0d want 280", period_avg); end
        total++; if (avg_vld !== 1'b1) begin bad++; $display("FAIL lock_avg_vld got %0b want 1", avg_vld); end
    endtask

    task automatic test_alternating();
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            run_period(17, 17);
            run_period(17, 18);
        end
        total++; if (locked !== 1'b1)   begin bad++; $display("FAIL alt_locked got %0b want 1", locked); end
        total++; if (n_lost !== 0)      begin bad++; $display("FAIL alt_lost got %0d want 0", n_lost); end
        total++; if (last_period !== 34) begin bad++; $display("FAIL alt_period got %0d want 34", last_period); end
`ifdef CLK_MON_AVG_EN
        total++; if (period_avg !== 11'd276) begin bad++; $display("FAIL alt_avg got %0d want 276", period_avg); end
`else
        total++; if (period_avg !== 11'd272) begin bad++; $display("FAIL alt_avg got %0d want 272", period_avg); end
`endif
    endtask

    task automatic test_bad_period();
        clear_counts();
        run_period(20, 20);
        run_period(17, 18);
        total++; if (n_lost !== 1)       begin bad++; $display("FAIL bad_lost got %0d want 1", n_lost); end
        total++; if (period !== 8'd40)   begin bad++; $display("FAIL bad_period got %0d want 40", period); end
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL bad_locked got %0b want 0", locked); end
        total++; if (dut.state_q !== MEASURE) begin bad++; $display("FAIL bad_state got %0d want %0d", dut.state_q, MEASURE); end
        total++; if (dut.good_cnt_q !== 5'd0) begin bad++; $display("FAIL bad_good_cnt got %0d want 0", dut.good_cnt_q); end
    endtask

    task automatic test_timeout();
        int waited;
        clear_counts();
        repeat (16) run_period(17, 18);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock got %0b want 1", locked); end
        clear_counts();
        waited = 0;
        while (n_lost == 0 && waited < 200) begin tick(); waited++; end
        total++; if (n_lost !== 1) begin bad++; $display("FAIL to_lost got %0d want 1", n_lost); end
        total++; if (lost_cyc - last_rise_cyc !== 71) begin bad++; $display("FAIL to_latency got %0d want 71", lost_cyc - last_rise_cyc); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL to_state got %0d want %0d", dut.state_q, IDLE); end
        total++; if (avg_vld !== 1'b0) begin bad++; $display("FAIL to_avg_vld got %0b want 0", avg_vld); end
        total++; if (locked !== 1'b0)  begin bad++; $display("FAIL to_locked got %0b want 0", locked); end
        clear_counts();
        run_period(17, 18);
        total++; if (n_vld !== 0) begin bad++; $display("FAIL idle_rise_vld got %0d want 0", n_vld); end
        total++; if (dut.state_q !== MEASURE) begin bad++; $display("FAIL idle_rise_state got %0d want %0d", dut.state_q, MEASURE); end
    endtask

    task automatic test_edge_timeout();
        clear_counts();
        run_period(35, 35);
        run_period(17, 18);
        total++; if (n_vld !== 2)         begin bad++; $display("FAIL edge_vld_count got %0d want 2", n_vld); end
        total++; if (period !== 8'd70)    begin bad++; $display("FAIL edge_period got %0d want 70", period); end
        total++; if (dut.state_q !== MEASURE) begin bad++; $display("FAIL edge_state got %0d want %0d", dut.state_q, MEASURE); end
        total++; if (n_lost !== 0)        begin bad++; $display("FAIL edge_lost got %0d want 0", n_lost); end
    endtask

    task automatic test_reset_locked();
        clear_counts();
        repeat (16) run_period(17, 18);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL prerst_locked got %0b want 1", locked); end
        clk_in = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        total++; if (locked !== 1'b0)     begin bad++; $display("FAIL mrst_locked got %0b want 0", locked); end
        total++; if (period !== 8'd0)     begin bad++; $display("FAIL mrst_period got %0d want 0", period); end
        total++; if (avg_vld !== 1'b0)    begin bad++; $display("FAIL mrst_avg_vld got %0b want 0", avg_vld); end
        total++; if (period_avg !== 11'd0) begin bad++; $display("FAIL mrst_avg got %0d want 0", period_avg); end
        total++; if (period_vld !== 1'b0) begin bad++; $display("FAIL mrst_pvld got %0b want 0", period_vld); end
        total++; if (rise !== 1'b0 || fall !== 1'b0) begin bad++; $display("FAIL mrst_edges got %0b%0b want 00", rise, fall); end
        tick();
        rst = 1'b0; clk_in = 1'b0;
        repeat (40) tick();
        total++; if (n_lost !== 0) begin bad++; $display("FAIL mrst_lost got %0d want 0", n_lost); end
        total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL mrst_state got %0d want %0d", dut.state_q, IDLE); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_alternating();
        test_bad_period();
        test_timeout();
        test_edge_timeout();
        test_reset_locked();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
